// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared types and default sizing for the programmable serial pattern
//   detector (seq_detect_prog) and its comparator (seq_match_cmp).
//   Contents:
//     state_t      FSM state encoding {IDLE, FILL, HUNT}
//     MAX_LEN_DEF  default maximum pattern length in bits
//     LEN_W_DEF    default width of a pattern length / fill count
//     CNT_W_DEF    default width of the optional match counter
//     len_mask()   low-order mask of 'len' ones, MAX_LEN_DEF bits wide
package seq_detect_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  // Lengths beyond MAX_LEN_DEF give an all-ones mask.
  function automatic logic [MAX_LEN_DEF-1:0] len_mask(input logic [LEN_W_DEF-1:0] len);
    logic [MAX_LEN_DEF-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN_DEF; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// seq_match_cmp
//   Purely combinational masked compare of the shift history against the
//   programmed pattern. Only the low 'len' bits take part; hist[0] is the
//   most recently received bit and lines up with pattern[0].
//   Ports:
//     hist     in  MAX_LEN  shift history (newest bit in [0])
//     pattern  in  MAX_LEN  programmed pattern (last bit in [0])
//     len      in  LEN_W    number of bits compared
//     hit      out 1        low 'len' bits of hist equal those of pattern
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = (((hist ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Runtime-programmable serial pattern detector. Shifts qualified bits into
//   a history register and pulses seq_seen (registered, one cycle) whenever
//   the last 'len' accepted bits equal the programmed pattern. Supports
//   overlapping and non-overlapping detection.
//   Optional feature macro: SEQ_DETECT_MATCH_CNT_EN adds match_cnt, a
//   saturating count of matches cleared only by reset.
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   synchronous, active-high
//     cfg_load     in   strobe: latch cfg_pattern/cfg_len/cfg_overlap, clear history
//     cfg_pattern  in   pattern; bit [len-1] is received first, bit [0] last
//     cfg_len      in   pattern length; 0 disables, >MAX_LEN saturates
//     cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//     in_valid     in   in_bit qualifier
//     in_bit       in   serial data
//     seq_seen     out  one-cycle match pulse
//     busy         out  high while in FILL
//     match_cnt    out  saturating match count (SEQ_DETECT_MATCH_CNT_EN only)
//
//   state | meaning
//   IDLE  | len == 0; bits shift in but never match
//   FILL  | fewer than len bits collected since last clear; busy = 1
//   HUNT  | at least len bits collected; compare active
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               seq_seen,
  output logic               busy
`ifdef SEQ_DETECT_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic               accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_load;
  logic               hit;
  logic               match;
  logic               restart;

  // Compare is done on the history as it will look after this bit shifts in,
  // so seq_seen lands exactly one cycle after the completing bit.
  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist_shift),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_comb begin
    accept     = in_valid && !cfg_load;
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    len_load   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    // IDLE guard matters: with len == 0 the mask is empty and hit is always 1.
    match      = accept && (state_q != IDLE) && (fill_inc >= len_q) && hit;
    restart    = match && !ovl_q;
    busy       = (state_q == FILL);

    state_d = state_q;
    if (cfg_load) begin
      state_d = (len_load == '0) ? IDLE : FILL;
    end else if (accept) begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FILL:    state_d = restart ? FILL : ((fill_inc >= len_q) ? HUNT : FILL);
        HUNT:    state_d = restart ? FILL : HUNT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b1;
      hist_q   <= '0;
      fill_q   <= '0;
      seq_seen <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_seen <= match;
      if (cfg_load) begin
        pat_q  <= cfg_pattern;
        len_q  <= len_load;
        ovl_q  <= cfg_overlap;
        hist_q <= '0;
        fill_q <= '0;
      end else if (accept) begin
        hist_q <= hist_shift;
        fill_q <= restart ? '0 : fill_inc;
      end
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  // Bumped on the same edge that raises seq_seen, so it reads the new
  // total while the pulse is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog
//   Self-checking bench for seq_detect_prog: directed scenarios followed by
//   randomized stimulus, every cycle compared against a bit-queue model.
//   Build with SEQ_DETECT_MATCH_CNT_EN to also check match_cnt.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       seq_seen;
  logic       busy;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [7:0] match_cnt;
`endif

  seq_detect_prog dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .seq_seen    (seq_seen),
    .busy        (busy)
`ifdef SEQ_DETECT_MATCH_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    pulses = 0;
  string phase  = "reset";

  // Reference model: configuration plus the list of bits received since the
  // last clear (newest at the back, at most MAX_LEN kept).
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         q[$];
  bit         exp_seen;
  bit         exp_busy;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = '0; m_len = 0; m_ovl = 1'b1; q.delete();
    exp_seen = 1'b0; exp_busy = 1'b0; m_cnt = 0;
  endtask

  task automatic model_clock(input bit v, input bit b, input bit ld,
                             input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    exp_seen = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      m_ovl = ovl;
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (m_len > 0 && q.size() >= m_len) begin
        exp_seen = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size()-1-i] != m_pat[i]) exp_seen = 1'b0;
      end
      if (exp_seen && !m_ovl) q.delete();
    end
    if (exp_seen && m_cnt < 255) m_cnt++;
    exp_busy = (m_len > 0) && (q.size() < m_len);
  endtask

  task automatic check_outputs();
    chk("seq_seen", 32'(seq_seen), 32'(exp_seen));
    chk("busy", 32'(busy), 32'(exp_busy));
`ifdef SEQ_DETECT_MATCH_CNT_EN
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
`endif
    if (seq_seen) pulses++;
  endtask

  task automatic step(input bit v, input bit b, input bit ld,
                      input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    in_valid = v; in_bit = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    @(posedge clk);
    model_clock(v, b, ld, pat, len, ovl);
    #1;
    check_outputs();
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    step(1'b0, 1'b0, 1'b1, pat, len, ovl);
  endtask

  task automatic feed_bit(input bit b);
    step(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  // Feeds n bits, bits[n-1] first.
  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] w;
    w = bits;
    for (int i = n - 1; i >= 0; i--) feed_bit(w[i]);
  endtask

  task automatic do_reset(input bit v, input bit b);
    reset = 1'b1; in_valid = v; in_bit = b; cfg_load = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(1'b0, 1'b0);

    phase = "t1_ovl";
    load(8'h0B, 4'd4, 1'b1);
    pulses = 0;
    feed(16'b1011011, 7);
    chk("pulses", 32'(pulses), 32'd2);

    phase = "t2_novl";
    load(8'h0B, 4'd4, 1'b0);
    pulses = 0;
    feed(16'b1011, 4);
    feed(16'b011, 3);
    chk("busy_end", 32'(busy), 32'd1);
    chk("pulses", 32'(pulses), 32'd1);

    phase = "t3_ovl";
    load(8'h03, 4'd2, 1'b1);
    pulses = 0;
    feed(16'b1111, 4);
    chk("pulses", 32'(pulses), 32'd3);

    phase = "t3_novl";
    load(8'h03, 4'd2, 1'b0);
    pulses = 0;
    feed(16'b1111, 4);
    chk("pulses", 32'(pulses), 32'd2);

    phase = "t4_gaps";
    load(8'h0B, 4'd4, 1'b1);
    pulses = 0;
    feed(16'b10, 2);
    idle(3);
    feed(16'b11, 2);
    chk("pulses", 32'(pulses), 32'd1);

    phase = "t4_load";
    load(8'h0B, 4'd4, 1'b1);
    pulses = 0;
    feed(16'b10, 2);
    step(1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b1);
    feed_bit(1'b1);
    chk("pulses", 32'(pulses), 32'd0);

    phase = "t5_len0";
    load(8'h00, 4'd0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) feed_bit(1'($urandom_range(0, 1)));
    chk("pulses", 32'(pulses), 32'd0);

    phase = "t5_len12";
    load(8'hFF, 4'd12, 1'b1);
    pulses = 0;
    feed(16'h7F, 7);
    chk("pulses7", 32'(pulses), 32'd0);
    feed_bit(1'b1);
    chk("pulses8", 32'(pulses), 32'd1);

    phase = "t6_cnt";
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 300; i++) feed_bit(1'b1);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    chk("cnt_sat", 32'(match_cnt), 32'd255);
`endif
    phase = "t6_rst";
    do_reset(1'b1, 1'b1);
    feed(16'hFF, 8);

    phase = "random";
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        load(8'($urandom), 4'($urandom_range(0, 4) == 0 ? $urandom_range(0, 15)
                                                         : $urandom_range(1, 4)),
             1'($urandom_range(0, 1)));
      end else if (r == 3) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
             8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
